// File: rtl/pipeline_hazard_unit_if.sv
// Bundle of stage-register fields in and pipeline-control outputs of the hazard unit.
// The stage logic drives the ID/EX/WB fields; the hazard unit answers with enables, flushes and selects.
interface pipeline_hazard_unit_if #(
   parameter int REG_AW   = 5,
   parameter int MC_LAT_W = 4,
   parameter int CNT_W    = 16
);
   logic [REG_AW-1:0]   rs1_D;
   logic [REG_AW-1:0]   rs2_D;
   logic [REG_AW-1:0]   rd_D;
   logic                reg_flag_D;
   logic                mc_op_D;
   logic [REG_AW-1:0]   rd_E;
   logic                reg_flag_E;
   logic                mem_read_E;
   logic                branch_E;
   logic                mc_start_E;
   logic [MC_LAT_W-1:0] mc_lat_E;
   logic [REG_AW-1:0]   rd_W;
   logic                reg_flag_W;

   logic                enable_F_D;
   logic                enable_D_R;
   logic                enable_R_E;
   logic                enable_E_W;
   logic                flush_F_D;
   logic                flush_D_R;
   logic                flush_R_E;
   logic                flush_E_W;
   logic [1:0]          fwd_rs1_sel;
   logic [1:0]          fwd_rs2_sel;
   logic                mc_busy;
   logic                mc_wb_valid;
   logic [REG_AW-1:0]   mc_wb_rd;
   logic [CNT_W-1:0]    stall_count;

   modport master (
      output rs1_D, rs2_D, rd_D, reg_flag_D, mc_op_D,
             rd_E, reg_flag_E, mem_read_E, branch_E, mc_start_E, mc_lat_E,
             rd_W, reg_flag_W,
      input  enable_F_D, enable_D_R, enable_R_E, enable_E_W,
             flush_F_D, flush_D_R, flush_R_E, flush_E_W,
             fwd_rs1_sel, fwd_rs2_sel, mc_busy, mc_wb_valid, mc_wb_rd, stall_count
   );

   modport slave (
      input  rs1_D, rs2_D, rd_D, reg_flag_D, mc_op_D,
             rd_E, reg_flag_E, mem_read_E, branch_E, mc_start_E, mc_lat_E,
             rd_W, reg_flag_W,
      output enable_F_D, enable_D_R, enable_R_E, enable_E_W,
             flush_F_D, flush_D_R, flush_R_E, flush_E_W,
             fwd_rs1_sel, fwd_rs2_sel, mc_busy, mc_wb_valid, mc_wb_rd, stall_count
   );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// Five-stage pipeline hazard unit: forwarding selects, load-use/RAW stalls, branch flushes,
// a scoreboard for one non-blocking multi-cycle unit and a saturating stall-cycle counter.
module pipeline_hazard_unit #(
   parameter int REG_AW   = 5,
   parameter int FWD_EN   = 1,
   parameter int MC_LAT_W = 4,
   parameter int CNT_W    = 16
) (
   input logic                  clk,
   input logic                  rst_n,
   pipeline_hazard_unit_if.slave hz
);
   localparam int NUM_REGS = 2 ** REG_AW;

   logic [NUM_REGS-1:0] pending_q, pending_d;
   logic [MC_LAT_W-1:0] mcCnt_q, mcCnt_d;
   logic                mcBusy_q, mcBusy_d;
   logic [REG_AW-1:0]   mcWbRd_q, mcWbRd_d;
   logic [CNT_W-1:0]    stallCount_q, stallCount_d;

   logic       mcWbValid;
   logic       sbHit, structHit, loadUse, rawHit, stallAny;
   logic       e1Match, e2Match, w1Match, w2Match;
   logic [1:0] fwd1Sel, fwd2Sel;
   logic       enableFD, enableDR, flushFD, flushDR, flushRE;

   // Register 0 is hardwired zero, so it can never carry a dependency.
   function automatic logic srcMatch(input logic [REG_AW-1:0] src,
                                     input logic [REG_AW-1:0] dst,
                                     input logic              flag);
      return flag && (src != '0) && (src == dst);
   endfunction

   assign e1Match   = srcMatch(hz.rs1_D, hz.rd_E, hz.reg_flag_E);
   assign e2Match   = srcMatch(hz.rs2_D, hz.rd_E, hz.reg_flag_E);
   assign w1Match   = srcMatch(hz.rs1_D, hz.rd_W, hz.reg_flag_W);
   assign w2Match   = srcMatch(hz.rs2_D, hz.rd_W, hz.reg_flag_W);
   assign mcWbValid = mcBusy_q && (mcCnt_q == MC_LAT_W'(1));
   assign sbHit     = pending_q[hz.rs1_D] | pending_q[hz.rs2_D] | (hz.reg_flag_D & pending_q[hz.rd_D]);
   assign structHit = hz.mc_op_D & mcBusy_q;

   always_comb begin
      fwd1Sel = 2'b00;
      fwd2Sel = 2'b00;
      loadUse = 1'b0;
      rawHit  = 1'b0;
      if (FWD_EN != 0) begin
         // An EX match wins over a WB match because EX holds the younger write.
         if (e1Match) begin
            if (hz.mem_read_E) loadUse = 1'b1;
            else               fwd1Sel = 2'b01;
         end else if (w1Match) begin
            fwd1Sel = 2'b10;
         end
         if (e2Match) begin
            if (hz.mem_read_E) loadUse = 1'b1;
            else               fwd2Sel = 2'b01;
         end else if (w2Match) begin
            fwd2Sel = 2'b10;
         end
      end else begin
         rawHit = e1Match | e2Match | w1Match | w2Match;
      end
   end

   assign stallAny = sbHit | structHit | loadUse | rawHit;

   always_comb begin
      enableFD = 1'b1;
      enableDR = 1'b1;
      flushFD  = 1'b0;
      flushDR  = 1'b0;
      flushRE  = 1'b0;
      if (hz.branch_E) begin
         flushFD = 1'b1;
         flushDR = 1'b1;
      end else if (stallAny) begin
         enableFD = 1'b0;
         enableDR = 1'b0;
         flushRE  = 1'b1;
      end
   end

   always_comb begin
      pending_d    = pending_q;
      mcCnt_d      = mcCnt_q;
      mcBusy_d     = mcBusy_q;
      mcWbRd_d     = mcWbRd_q;
      stallCount_d = stallCount_q;
      if (mcBusy_q) begin
         if (mcWbValid) begin
            mcBusy_d            = 1'b0;
            mcCnt_d             = '0;
            pending_d[mcWbRd_q] = 1'b0;
         end else begin
            mcCnt_d = mcCnt_q - MC_LAT_W'(1);
         end
      end else if (hz.mc_start_E) begin
         // A zero latency still needs one cycle so the result has a write-back slot.
         mcBusy_d = 1'b1;
         mcCnt_d  = (hz.mc_lat_E == '0) ? MC_LAT_W'(1) : hz.mc_lat_E;
         mcWbRd_d = hz.rd_E;
         if (hz.rd_E != '0) pending_d[hz.rd_E] = 1'b1;
      end
      if (!enableFD && (stallCount_q != '1)) stallCount_d = stallCount_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q    <= '0;
         mcCnt_q      <= '0;
         mcBusy_q     <= 1'b0;
         mcWbRd_q     <= '0;
         stallCount_q <= '0;
      end else begin
         pending_q    <= pending_d;
         mcCnt_q      <= mcCnt_d;
         mcBusy_q     <= mcBusy_d;
         mcWbRd_q     <= mcWbRd_d;
         stallCount_q <= stallCount_d;
      end
   end

   assign hz.enable_F_D  = enableFD;
   assign hz.enable_D_R  = enableDR;
   assign hz.enable_R_E  = 1'b1;
   assign hz.enable_E_W  = 1'b1;
   assign hz.flush_F_D   = flushFD;
   assign hz.flush_D_R   = flushDR;
   assign hz.flush_R_E   = flushRE;
   assign hz.flush_E_W   = 1'b0;
   assign hz.fwd_rs1_sel = fwd1Sel;
   assign hz.fwd_rs2_sel = fwd2Sel;
   assign hz.mc_busy     = mcBusy_q;
   assign hz.mc_wb_valid = mcWbValid;
   assign hz.mc_wb_rd    = mcWbRd_q;
   assign hz.stall_count = stallCount_q;

   // The structural stall keeps a second issue out while busy; if one slips through it is dropped.
   mcStartWhileBusy: assert property (@(posedge clk) disable iff (!rst_n) !(hz.mc_start_E && mcBusy_q));
endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench for pipeline_hazard_unit: one forwarding instance and one non-forwarding
// instance with a narrow stall counter so saturation is reached quickly.
module tb_pipeline_hazard_unit;
   logic clk;
   logic rst_n;
   int   checkCount = 0;
   int   errorCount = 0;

   pipeline_hazard_unit_if #(.REG_AW(5), .MC_LAT_W(4), .CNT_W(16)) ifF ();
   pipeline_hazard_unit_if #(.REG_AW(5), .MC_LAT_W(4), .CNT_W(4))  ifN ();

   pipeline_hazard_unit #(.REG_AW(5), .FWD_EN(1), .MC_LAT_W(4), .CNT_W(16)) dutF (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (ifF.slave)
   );

   pipeline_hazard_unit #(.REG_AW(5), .FWD_EN(0), .MC_LAT_W(4), .CNT_W(4)) dutN (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (ifN.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   // Drives the ALU-path fields of the forwarding instance and idles everything else.
   task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rdE,
                                input logic flagE, input logic memRead, input logic [4:0] rdW,
                                input logic flagW);
      ifF.rs1_D      = rs1;
      ifF.rs2_D      = rs2;
      ifF.rd_D       = '0;
      ifF.reg_flag_D = 1'b0;
      ifF.mc_op_D    = 1'b0;
      ifF.rd_E       = rdE;
      ifF.reg_flag_E = flagE;
      ifF.mem_read_E = memRead;
      ifF.branch_E   = 1'b0;
      ifF.mc_start_E = 1'b0;
      ifF.mc_lat_E   = '0;
      ifF.rd_W       = rdW;
      ifF.reg_flag_W = flagW;
   endtask

   task automatic clearN();
      ifN.rs1_D      = '0;
      ifN.rs2_D      = '0;
      ifN.rd_D       = '0;
      ifN.reg_flag_D = 1'b0;
      ifN.mc_op_D    = 1'b0;
      ifN.rd_E       = '0;
      ifN.reg_flag_E = 1'b0;
      ifN.mem_read_E = 1'b0;
      ifN.branch_E   = 1'b0;
      ifN.mc_start_E = 1'b0;
      ifN.mc_lat_E   = '0;
      ifN.rd_W       = '0;
      ifN.reg_flag_W = 1'b0;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      clearN();
      #2;
      checkOutput("reset_mc_busy", 32'(ifF.mc_busy), 32'd0);
      checkOutput("reset_stall_count", 32'(ifF.stall_count), 32'd0);
      checkOutput("reset_wb_valid", 32'(ifF.mc_wb_valid), 32'd0);
      checkOutput("reset_wb_rd", 32'(ifF.mc_wb_rd), 32'd0);
      checkOutput("reset_enable_F_D", 32'(ifF.enable_F_D), 32'd1);
      checkOutput("reset_flush_R_E", 32'(ifF.flush_R_E), 32'd0);
      checkOutput("reset_static_outs", {28'd0, ifF.enable_R_E, ifF.enable_E_W, ifF.flush_E_W, ifF.flush_F_D}, 32'b1100);
      nextCycle();
      nextCycle();
      rst_n = 1'b1;
      nextCycle();

      // ALU result in EX forwarded to rs1
      applyStimulus(5, 0, 5, 1, 0, 0, 0);
      #1;
      checkOutput("fwd_ex_rs1_sel", 32'(ifF.fwd_rs1_sel), 32'd1);
      checkOutput("fwd_ex_no_stall", 32'(ifF.enable_F_D), 32'd1);
      nextCycle();

      // Load in EX feeding ID: one stall cycle
      applyStimulus(5, 0, 5, 1, 1, 0, 0);
      #1;
      checkOutput("load_use_enable_F_D", 32'(ifF.enable_F_D), 32'd0);
      checkOutput("load_use_enable_D_R", 32'(ifF.enable_D_R), 32'd0);
      checkOutput("load_use_flush_R_E", 32'(ifF.flush_R_E), 32'd1);
      nextCycle();

      applyStimulus(5, 0, 0, 0, 0, 5, 1);
      #1;
      checkOutput("load_wb_rs1_sel", 32'(ifF.fwd_rs1_sel), 32'd2);
      checkOutput("load_wb_no_stall", 32'(ifF.enable_F_D), 32'd1);
      checkOutput("load_use_stall_count", 32'(ifF.stall_count), 32'd1);
      nextCycle();

      // EX match beats WB match; flag-less EX destination never matches
      applyStimulus(3, 5, 5, 1, 0, 5, 1);
      #1;
      checkOutput("ex_precedence_rs2_sel", 32'(ifF.fwd_rs2_sel), 32'd1);
      checkOutput("no_match_rs1_sel", 32'(ifF.fwd_rs1_sel), 32'd0);
      applyStimulus(5, 0, 5, 0, 0, 0, 0);
      #1;
      checkOutput("no_flag_rs1_sel", 32'(ifF.fwd_rs1_sel), 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      nextCycle();

      // Forwarding disabled: WB and EX matches stall, selects stay 00, x0 never stalls
      ifN.rd_W = 5'd7; ifN.reg_flag_W = 1'b1; ifN.rs2_D = 5'd7;
      #1;
      checkOutput("raw_wb_enable_F_D", 32'(ifN.enable_F_D), 32'd0);
      checkOutput("raw_wb_rs2_sel", 32'(ifN.fwd_rs2_sel), 32'd0);
      checkOutput("raw_wb_flush_R_E", 32'(ifN.flush_R_E), 32'd1);
      nextCycle();
      clearN();
      ifN.rd_E = 5'd4; ifN.reg_flag_E = 1'b1; ifN.rs1_D = 5'd4;
      #1;
      checkOutput("raw_ex_enable_F_D", 32'(ifN.enable_F_D), 32'd0);
      checkOutput("raw_ex_rs1_sel", 32'(ifN.fwd_rs1_sel), 32'd0);
      nextCycle();
      clearN();
      ifN.reg_flag_E = 1'b1;
      #1;
      checkOutput("x0_no_stall", 32'(ifN.enable_F_D), 32'd1);
      checkOutput("raw_stall_count", 32'(ifN.stall_count), 32'd2);
      nextCycle();
      clearN();

      // Multi-cycle op to x9 with latency 4, dependent instruction follows
      applyStimulus(0, 0, 9, 0, 0, 0, 0);
      ifF.mc_start_E = 1'b1;
      ifF.mc_lat_E   = 4'd4;
      #1;
      checkOutput("mc_issue_busy", 32'(ifF.mc_busy), 32'd0);
      checkOutput("mc_issue_no_stall", 32'(ifF.enable_F_D), 32'd1);
      nextCycle();
      applyStimulus(9, 0, 0, 0, 0, 0, 0);
      #1;
      checkOutput("mc_busy_set", 32'(ifF.mc_busy), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         checkOutput($sformatf("mc_dep_stall_%0d", i), 32'(ifF.enable_F_D), 32'd0);
         checkOutput($sformatf("mc_wb_valid_%0d", i), 32'(ifF.mc_wb_valid), (i == 4) ? 32'd1 : 32'd0);
         if (i == 4) checkOutput("mc_wb_rd", 32'(ifF.mc_wb_rd), 32'd9);
         nextCycle();
         #1;
      end
      checkOutput("mc_release", 32'(ifF.enable_F_D), 32'd1);
      checkOutput("mc_busy_clear", 32'(ifF.mc_busy), 32'd0);
      checkOutput("mc_stall_count", 32'(ifF.stall_count), 32'd5);
      nextCycle();

      // Zero latency completes in one cycle; a second mc op stalls structurally meanwhile
      applyStimulus(0, 0, 3, 0, 0, 0, 0);
      ifF.mc_start_E = 1'b1;
      ifF.mc_lat_E   = 4'd0;
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      ifF.mc_op_D    = 1'b1;
      ifF.rd_D       = 5'd4;
      ifF.reg_flag_D = 1'b1;
      #1;
      checkOutput("lat0_wb_valid", 32'(ifF.mc_wb_valid), 32'd1);
      checkOutput("lat0_wb_rd", 32'(ifF.mc_wb_rd), 32'd3);
      checkOutput("struct_stall", 32'(ifF.enable_F_D), 32'd0);
      nextCycle();
      ifF.rs1_D = 5'd3;
      #1;
      checkOutput("struct_release", 32'(ifF.enable_F_D), 32'd1);
      checkOutput("lat0_busy_clear", 32'(ifF.mc_busy), 32'd0);
      checkOutput("struct_stall_count", 32'(ifF.stall_count), 32'd6);
      nextCycle();

      // Branch overrides a load-use hazard
      applyStimulus(6, 0, 6, 1, 1, 0, 0);
      ifF.branch_E = 1'b1;
      #1;
      checkOutput("branch_flush_F_D", 32'(ifF.flush_F_D), 32'd1);
      checkOutput("branch_flush_D_R", 32'(ifF.flush_D_R), 32'd1);
      checkOutput("branch_enables", {30'd0, ifF.enable_F_D, ifF.enable_D_R}, 32'b11);
      checkOutput("branch_flush_R_E", 32'(ifF.flush_R_E), 32'd0);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      #1;
      checkOutput("branch_stall_count", 32'(ifF.stall_count), 32'd6);
      nextCycle();

      // Reset while the multi-cycle op has two cycles left
      applyStimulus(0, 0, 10, 0, 0, 0, 0);
      ifF.mc_start_E = 1'b1;
      ifF.mc_lat_E   = 4'd4;
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      nextCycle();
      nextCycle();
      checkOutput("pre_reset_busy", 32'(ifF.mc_busy), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("mid_reset_busy", 32'(ifF.mc_busy), 32'd0);
      checkOutput("mid_reset_wb_valid", 32'(ifF.mc_wb_valid), 32'd0);
      checkOutput("mid_reset_stall_count", 32'(ifF.stall_count), 32'd0);
      #1;
      rst_n = 1'b1;
      applyStimulus(10, 0, 0, 0, 0, 0, 0);
      #1;
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("post_reset_pending_%0d", i), 32'(ifF.enable_F_D), 32'd1);
         checkOutput($sformatf("post_reset_wb_valid_%0d", i), 32'(ifF.mc_wb_valid), 32'd0);
         nextCycle();
      end

      // Counter saturation on the 4-bit instance: 2^4+3 stall cycles
      ifN.rd_W = 5'd7; ifN.reg_flag_W = 1'b1; ifN.rs2_D = 5'd7;
      for (int i = 1; i <= 19; i++) begin
         nextCycle();
         if (i == 14) checkOutput("sat_count_14", 32'(ifN.stall_count), 32'd14);
      end
      checkOutput("sat_count_max", 32'(ifN.stall_count), 32'd15);
      clearN();
      nextCycle();

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end
endmodule

// File: doc/pipeline_hazard_unit.md
Name: pipeline_hazard_unit

Overview:
- Parametrised successor to the ERV25 five-stage pipeline control (IF, ID, RR, EX, WB).
- Generates latch enables/flushes from data and control hazards.
- Adds operand forwarding selects, load-use detection, and a register scoreboard for one non-blocking multi-cycle unit (mul/div) with an internal latency counter.
- Adds a saturating stall-cycle performance counter.
- Sits between the stage registers and the operand muxes in RR.

Parameters:
REG_AW, 5, register address width; NUM_REGS = 2**REG_AW; register 0 is hardwired zero.
FWD_EN, 1, 1 = forward ALU results from EX/WB; 0 = stall on every RAW match.
MC_LAT_W, 4, width of multi-cycle latency field and counter.
CNT_W, 16, stall counter width.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
rs1_D  in  REG_AW  ID source 1
rs2_D  in  REG_AW  ID source 2
rd_D  in  REG_AW  ID destination
reg_flag_D  in  1  ID instruction writes rd
mc_op_D  in  1  ID instruction uses the multi-cycle unit
rd_E  in  REG_AW  EX destination
reg_flag_E  in  1  EX instruction writes rd (single-cycle path)
mem_read_E  in  1  EX instruction is a load
branch_E  in  1  branch taken in EX
mc_start_E  in  1  EX instruction issues to the multi-cycle unit
mc_lat_E  in  MC_LAT_W  its latency in cycles
rd_W  in  REG_AW  WB destination
reg_flag_W  in  1  WB writes rd
enable_F_D, enable_D_R, enable_R_E, enable_E_W  out  1 each  latch enables
flush_F_D, flush_D_R, flush_R_E, flush_E_W  out  1 each  latch flushes
fwd_rs1_sel, fwd_rs2_sel  out  2  00 regfile, 01 EX result, 10 WB result
mc_busy  out  1  multi-cycle unit occupied
mc_wb_valid  out  1  multi-cycle result writes this cycle
mc_wb_rd  out  REG_AW  its destination
stall_count  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (async, rst_n=0):
  - pending[NUM_REGS-1:0]=0, mc_cnt=0, mc_busy=0, mc_wb_rd=0, stall_count=0.
  - Combinational outputs follow the rules below from the cleared state.
- Match rule: a source matches a destination only if the addresses are equal, the source is nonzero, and the writer's flag is set. Register 0 never matches, is never set pending, and is never forwarded.
- Hazards, each evaluated per source (rs1, rs2):
  - sb_hit: pending[rs]=1, or reg_flag_D and pending[rd_D]=1 (WAW).
  - struct_hit: mc_op_D and mc_busy.
  - E match, FWD_EN=1:
    - mem_read_E=1 → load_use stall.
    - otherwise fwd_sel=01, no stall.
  - W match (no E match), FWD_EN=1 → fwd_sel=10, no stall.
  - FWD_EN=0: any E or W match → raw stall; fwd_sel is always 00.
  - The E match takes precedence over the W match.
- Priority, highest first:
  1. branch_E: flush_F_D=1, flush_D_R=1, all enables 1. Stall causes are ignored. A multi-cycle op issued by the branch itself still starts.
  2. Any stall (sb_hit | struct_hit | load_use | raw): enable_F_D=0, enable_D_R=0, flush_R_E=1.
  3. Default: all enables 1, all flushes 0.
- enable_R_E, enable_E_W and flush_E_W are always 1, 1, 0 in this revision.
- Scoreboard and counter:
  - On mc_start_E with mc_busy=0:
    - mc_busy<=1.
    - mc_cnt<=max(mc_lat_E,1).
    - mc_wb_rd<=rd_E.
    - pending[rd_E]<=1 if rd_E≠0.
  - While busy: mc_cnt decrements each cycle.
  - mc_wb_valid = mc_busy & (mc_cnt==1), combinational.
  - On the edge after mc_wb_valid: pending[mc_wb_rd]<=0, mc_busy<=0.
  - Dependent instructions stall through the mc_wb_valid cycle and advance on the following cycle. There is no forwarding from the multi-cycle unit.
  - mc_start_E while busy cannot occur because struct_hit prevents it. If it does occur, it is ignored and a simulation assertion fires.
- stall_count increments on every cycle with enable_F_D=0, saturating at all-ones.
- Reset mid-operation drops the pending op. No mc_wb_valid is generated for it.

Test Plan:
1. FWD_EN=1; EX ALU op rd_E=5, ID rs1_D=5 → fwd_rs1_sel=01, no stall. Same case with mem_read_E=1 → 1 stall cycle (enable_F_D=0, flush_R_E=1), then fwd_rs1_sel=10 once the load reaches WB.
2. FWD_EN=0; rd_W=7, rs2_D=7 → stall one cycle, fwd_rs2_sel=00. rs1_D=0 with rd_E=0 and reg_flag_E=1 → no stall.
3. mc_start_E, rd_E=9, mc_lat_E=4; next ID reads x9 → stalled 4 cycles, mc_wb_valid in the 4th cycle with mc_wb_rd=9, released on the 5th. stall_count=4.
4. A second mc_op_D while busy → struct stall until mc_busy falls. mc_lat_E=0 → result in 1 cycle.
5. branch_E together with a load-use hazard → flush_F_D=flush_D_R=1, enables 1, stall_count unchanged.
6. Assert rst_n=0 mid multi-cycle op with mc_cnt=2 → mc_busy=0, pending clear, no mc_wb_valid. Force 2^CNT_W+3 stall cycles → stall_count saturates at all-ones.
